// File: rtl/itcm_pkg.sv
// Shared types for the ITCM arbiter: default address width,
// FSM state encoding and read-response tag encoding.
package itcm_pkg;

    localparam int ITCM_ADDR_WIDTH = 12;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_IF   = 2'b01,
        TAG_D    = 2'b10
    } tag_e;

endpackage

// File: rtl/itcm_arbiter_if.sv
// Bundle of loader, fetch, data and itcm_ram port signals.
// slave = arbiter view, master = SoC / requester view.
interface itcm_arbiter_if
    import itcm_pkg::*;
#(
    parameter int ADDR_WIDTH = ITCM_ADDR_WIDTH
);
    logic                  boot_req;
    logic [ADDR_WIDTH-1:0] boot_addr;
    logic [31:0]           boot_wdata;
    logic                  boot_done;
    logic                  boot_gnt;
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [31:0]           if_rdata;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [31:0]           d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [31:0]           d_rdata;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [31:0]           ram_data;
    logic                  ram_wren;
    logic [31:0]           ram_q;
    logic                  core_hold;

    modport slave (
        input  boot_req, boot_addr, boot_wdata, boot_done,
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  ram_q,
        output boot_gnt, if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output ram_address, ram_data, ram_wren,
        output core_hold
    );

    modport master (
        output boot_req, boot_addr, boot_wdata, boot_done,
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output ram_q,
        input  boot_gnt, if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  ram_address, ram_data, ram_wren,
        input  core_hold
    );

endinterface

// File: rtl/itcm_prio_sel.sv
// Two-way priority select between data and fetch; returns one-hot
// grant {data, fetch}. i_promote lifts fetch above data.
module itcm_prio_sel (
    input  logic       i_if_req,
    input  logic       i_d_req,
    input  logic       i_promote,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        if (i_promote) begin
            if (i_if_req)     o_gnt = 2'b01;
            else if (i_d_req) o_gnt = 2'b10;
        end else begin
            if (i_d_req)       o_gnt = 2'b10;
            else if (i_if_req) o_gnt = 2'b01;
        end
    end

endmodule

// File: rtl/itcm_arbiter.sv
// Single-port ITCM arbiter: boot loader / fetch / data sharing itcm_ram.
// Boot phase and core_hold exist only when ITCM_ARB_BOOT_EN is defined.
module itcm_arbiter
    import itcm_pkg::*;
#(
    parameter int ADDR_WIDTH   = ITCM_ADDR_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input logic          clk_in,
    input logic          rst_n,
    itcm_arbiter_if.slave bus
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_e          r_state;
    tag_e            r_tag;
    logic [CW-1:0]   r_cnt;
    logic            w_run;
    logic            w_boot_gnt;
    logic            w_if_gnt;
    logic            w_d_gnt;
    logic [1:0]      w_sel;

    // Everything is gated by rst_n so a reset cycle also kills rvalid.
    assign w_run = rst_n && (r_state == RUN);

`ifdef ITCM_ARB_BOOT_EN
    assign w_boot_gnt    = rst_n && (r_state == BOOT) && bus.boot_req;
    assign bus.core_hold = !rst_n || (r_state == BOOT);
`else
    logic w_unused_boot;
    assign w_unused_boot = ^{bus.boot_req, bus.boot_addr,
                             bus.boot_wdata, bus.boot_done};
    assign w_boot_gnt    = 1'b0;
    assign bus.core_hold = 1'b0;
`endif

    itcm_prio_sel u_sel (
        .i_if_req  (bus.if_req),
        .i_d_req   (bus.d_req),
        .i_promote (r_cnt == LIMIT),
        .o_gnt     (w_sel)
    );

    assign w_if_gnt = w_run && w_sel[0];
    assign w_d_gnt  = w_run && w_sel[1];

    assign bus.boot_gnt  = w_boot_gnt;
    assign bus.if_gnt    = w_if_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.if_rvalid = rst_n && (r_tag == TAG_IF);
    assign bus.d_rvalid  = rst_n && (r_tag == TAG_D);
    assign bus.if_rdata  = bus.ram_q;
    assign bus.d_rdata   = bus.ram_q;

    always_comb begin
        bus.ram_address = '0;
        bus.ram_data    = '0;
        bus.ram_wren    = 1'b0;
        unique case (1'b1)
            w_boot_gnt: begin
                bus.ram_address = bus.boot_addr;
                bus.ram_data    = bus.boot_wdata;
                bus.ram_wren    = 1'b1;
            end
            w_d_gnt: begin
                bus.ram_address = bus.d_addr;
                bus.ram_data    = bus.d_wdata;
                bus.ram_wren    = bus.d_we;
            end
            w_if_gnt: begin
                bus.ram_address = bus.if_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
`ifdef ITCM_ARB_BOOT_EN
            r_state <= BOOT;
`else
            r_state <= RUN;
`endif
            r_tag   <= TAG_NONE;
            r_cnt   <= '0;
        end else begin
`ifdef ITCM_ARB_BOOT_EN
            if (r_state == BOOT && bus.boot_done)
                r_state <= RUN;
`endif
            if (w_if_gnt)
                r_tag <= TAG_IF;
            else if (w_d_gnt && !bus.d_we)
                r_tag <= TAG_D;
            else
                r_tag <= TAG_NONE;

            if (!w_run || !bus.if_req || w_if_gnt)
                r_cnt <= '0;
            else if (r_cnt != LIMIT)
                r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_itcm_arbiter.sv
// Table-driven bench for itcm_arbiter with an itcm_ram model and a
// read-response scoreboard; covers boot (if ITCM_ARB_BOOT_EN) and run.
module tb_itcm_arbiter;

    logic clk_in = 1'b1;
    logic rst_n;
    always #5 clk_in = ~clk_in;

    itcm_arbiter_if #(.ADDR_WIDTH(12)) bus ();

    itcm_arbiter #(
        .ADDR_WIDTH   (12),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    logic [31:0] mem [0:4095];
    always @(posedge clk_in) begin
        if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
        bus.ram_q <= mem[bus.ram_address];
    end

    typedef struct {
        logic        rst;
        logic        breq;
        logic [11:0] baddr;
        logic [31:0] bwd;
        logic        bdone;
        logic        ireq;
        logic [11:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [11:0] daddr;
        logic [31:0] dwd;
        logic        ebg;
        logic        eig;
        logic        edg;
        logic        ehold;
    } vec_t;

    typedef struct {
        logic        iv;
        logic        dv;
        logic [31:0] data;
    } sb_t;

    vec_t        tv[$];
    sb_t         sbq[$];
    logic [31:0] sh [0:4095];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic add(
        input logic rst, input logic breq, input logic [11:0] baddr,
        input logic [31:0] bwd, input logic bdone,
        input logic ireq, input logic [11:0] iaddr,
        input logic dreq, input logic dwe, input logic [11:0] daddr,
        input logic [31:0] dwd,
        input logic ebg, input logic eig, input logic edg,
        input logic ehold);
        vec_t v;
        v = '{rst, breq, baddr, bwd, bdone, ireq, iaddr,
              dreq, dwe, daddr, dwd, ebg, eig, edg, ehold};
        tv.push_back(v);
    endtask

    task automatic idle();
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @vec %0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n          = !v.rst;
        bus.boot_req   = v.breq;
        bus.boot_addr  = v.baddr;
        bus.boot_wdata = v.bwd;
        bus.boot_done  = v.bdone;
        bus.if_req     = v.ireq;
        bus.if_addr    = v.iaddr;
        bus.d_req      = v.dreq;
        bus.d_we       = v.dwe;
        bus.d_addr     = v.daddr;
        bus.d_wdata    = v.dwd;
    endtask

    task automatic check(input vec_t v, input int idx);
        sb_t         e;
        sb_t         n;
        logic        ewr;
        logic [11:0] ea;
        logic [31:0] ed;
        e = '{1'b0, 1'b0, 32'h0};
        if (sbq.size() > 0) e = sbq.pop_front();
        if (v.rst) begin
            e.iv = 1'b0;
            e.dv = 1'b0;
        end
        chk("if_rvalid", idx, 32'(bus.if_rvalid), 32'(e.iv));
        chk("d_rvalid", idx, 32'(bus.d_rvalid), 32'(e.dv));
        if (e.iv) chk("if_rdata", idx, bus.if_rdata, e.data);
        if (e.dv) chk("d_rdata", idx, bus.d_rdata, e.data);

        ewr = v.ebg || (v.edg && v.dwe);
        ea  = v.ebg ? v.baddr : v.eig ? v.iaddr : v.edg ? v.daddr : 12'h0;
        ed  = v.ebg ? v.bwd : v.dwd;
        chk("boot_gnt", idx, 32'(bus.boot_gnt), 32'(v.ebg));
        chk("if_gnt", idx, 32'(bus.if_gnt), 32'(v.eig));
        chk("d_gnt", idx, 32'(bus.d_gnt), 32'(v.edg));
        chk("core_hold", idx, 32'(bus.core_hold), 32'(v.ehold));
        chk("ram_wren", idx, 32'(bus.ram_wren), 32'(ewr));
        chk("ram_address", idx, 32'(bus.ram_address), 32'(ea));
        if (ewr) chk("ram_data", idx, bus.ram_data, ed);

        n.iv   = !v.rst && v.eig;
        n.dv   = !v.rst && v.edg && !v.dwe;
        n.data = sh[v.eig ? v.iaddr : v.daddr];
        sbq.push_back(n);
        if (ewr) sh[ea] = ed;
    endtask

    initial begin
`ifdef ITCM_ARB_BOOT_EN
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 12'h010, 32'hDEADBEEF, 0, 1, 12'h010,
            1, 0, 12'h020, 0, 1, 0, 0, 1);
        add(0, 1, 12'h011, 32'hCAFEF00D, 1, 1, 12'h010,
            1, 0, 12'h020, 0, 1, 0, 0, 1);
`else
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,
            1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,
            1, 1, 12'h011, 32'hCAFEF00D, 0, 0, 1, 0);
`endif
        // Run mode: boot port is ignored, fetch alone is served.
        add(0, 1, 12'h050, 32'h1, 0, 1, 12'h010,
            0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        // Contended: four data grants, then promoted fetch, twice.
        for (int k = 0; k < 10; k++)
            add(0, 0, 0, 0, 0, 1, 12'h010, 1, 0, 12'h011, 0,
                0, (k % 5 == 4), (k % 5 != 4), 0);
        idle();
        add(0, 0, 0, 0, 0, 0, 0, 1, 1, 12'h020, 32'h12345678, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 12'h020, 0, 0, 0, 1, 0);
        idle();
        add(0, 0, 0, 0, 0, 1, 12'h010, 0, 0, 0, 0, 0, 1, 0, 0);
`ifdef ITCM_ARB_BOOT_EN
        add(1, 0, 0, 0, 0, 1, 12'h010, 1, 0, 12'h011, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 1, 12'h010, 1, 0, 12'h011, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 12'h010, 0, 0, 0, 0, 0, 1, 0, 0);
`else
        add(1, 0, 0, 0, 0, 1, 12'h010, 1, 0, 12'h011, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 12'h010, 1, 0, 12'h011, 0, 0, 0, 1, 0);
`endif
        idle();
        idle();

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i]);
            @(negedge clk_in);
            check(tv[i], i);
            @(posedge clk_in);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
